// File: rtl/csr_access_unit_pkg.sv
// csr_access_unit_pkg
//   Shared encodings for the CSR access unit. The unit and any block that
//   builds requests for it import this package:
//     - CSR_OP_* operation codes carried on req_op
//     - ECODE_ERTN / ECODE_IPE codes presented on the file's ecode port
//     - csr_state_t FSM state encoding
//     - next_pc() helper for the redirect after a CSR write
package csr_access_unit_pkg;

   localparam logic [2:0] CSR_OP_RD   = 3'd0;
   localparam logic [2:0] CSR_OP_WR   = 3'd1;
   localparam logic [2:0] CSR_OP_XCHG = 3'd2;
   localparam logic [2:0] CSR_OP_ERTN = 3'd3;
   localparam logic [2:0] CSR_OP_EXC  = 3'd4;

   // The register file recognises an exception return by this code alone.
   localparam logic [7:0] ECODE_ERTN  = 8'h3F;
   // Instruction privilege error.
   localparam logic [7:0] ECODE_IPE   = 8'h0E;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2,
      ST_FLUSH  = 2'd3
   } csr_state_t;

   // Redirect target after a CSR write; the sum wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] cur_pc, input logic [31:0] inc);
      return cur_pc + inc;
   endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if
//   Pipeline-side bundle of the CSR access unit.
//     req_*   : operation offered by execute (valid/ready handshake)
//     resp_*  : old CSR value returned to writeback (valid/ready handshake)
//     flush_* : one-cycle pipeline flush with redirect PC
//   Modports: master = execute/writeback side, slave = csr_access_unit.
interface csr_access_unit_if #(
   parameter int DEST_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [13:0]       req_csr_num;
   logic [31:0]       req_wdata;
   logic [31:0]       req_mask;
   logic [DEST_W-1:0] req_dest;
   logic [31:0]       req_pc;
   logic [7:0]        req_ecode;
   logic              req_esubcode;
   logic [31:0]       req_vaddr;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic [DEST_W-1:0] resp_dest;
   logic              flush_valid;
   logic [31:0]       flush_pc;

   modport master (
      output req_valid, req_op, req_csr_num, req_wdata, req_mask, req_dest,
             req_pc, req_ecode, req_esubcode, req_vaddr, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_dest, flush_valid, flush_pc
   );

   modport slave (
      input  req_valid, req_op, req_csr_num, req_wdata, req_mask, req_dest,
             req_pc, req_ecode, req_esubcode, req_vaddr, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_dest, flush_valid, flush_pc
   );
endinterface

// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Serialising initiator for the CSR register file. Takes one CSR-class
//   operation at a time from execute (RD, WR, XCHG, ERTN, EXC), performs it
//   on the file's access/exception port in a single ACCESS cycle, returns the
//   old CSR value to writeback and/or issues a flush with redirect PC.
//   Pending interrupts seen while an operation is offered are turned into a
//   synthetic exception instead of accepting the operation.
//   Ports:
//     clk, rstn            clock, asynchronous active-low reset
//     pipe (slave)         request / response / flush bundle
//     csr_plv              current privilege level
//     csr_addr..csr_rdata  register-file access port
//     ex_en..vaddr         register-file exception port
//     has_int, int_ecode   pending interrupt from the file
//     new_pc, ex_entryPC   ERTN target and exception entry from the file
//   Optional feature macro: CSR_PRIV_CHECK_EN (RD/WR/XCHG/ERTN at csr_plv!=0
//   become an IPE exception).
module csr_access_unit
   import csr_access_unit_pkg::*;
#(
   parameter int DEST_W = 5,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             rstn,
   csr_access_unit_if.slave pipe,
   input  logic [1:0]       csr_plv,
   output logic [13:0]      csr_addr,
   output logic             csr_re,
   output logic             csr_we,
   output logic [31:0]      csr_wmask,
   output logic [31:0]      csr_wdata,
   input  logic [31:0]      csr_rdata,
   output logic             ex_en,
   output logic [7:0]       ecode,
   output logic             esubcode,
   output logic [31:0]      pc,
   output logic [31:0]      vaddr,
   input  logic             has_int,
   input  logic [7:0]       int_ecode,
   input  logic [31:0]      new_pc,
   input  logic [31:0]      ex_entryPC
);

   localparam logic [31:0] PC_INC_W = 32'(PC_INC);

   csr_state_t        state_r, state_nx;
   logic              started_r;
   logic              accept_s, take_int_s, priv_fault_s;
   logic [2:0]        op_r;
   logic [13:0]       num_r;
   logic [31:0]       wdata_r, mask_r, pc_r, vaddr_r, rdata_r, flush_pc_r;
   logic [DEST_W-1:0] dest_r;
   logic [7:0]        ecode_r;
   logic              esub_r;

`ifdef CSR_PRIV_CHECK_EN
   // Any non-exception operation issued from user privilege faults.
   assign priv_fault_s = (op_r != CSR_OP_EXC) && (csr_plv != 2'd0);
`else
   logic unused_plv_s;
   assign priv_fault_s = 1'b0;
   assign unused_plv_s = ^csr_plv;
`endif

   assign pipe.resp_valid  = (state_r == ST_RESP);
   assign pipe.resp_rdata  = rdata_r;
   assign pipe.resp_dest   = dest_r;
   assign pipe.flush_valid = (state_r == ST_FLUSH);
   assign pipe.flush_pc    = flush_pc_r;

   // State register; started_r keeps req_ready low during and right at reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         started_r <= 1'b0;
      end else begin
         state_r   <= state_nx;
         started_r <= 1'b1;
      end
   end

   // Next state, handshake and file-port drive. The file port is non-zero
   // only in ACCESS because the file decodes ecode without a qualifier.
   always_comb begin
      state_nx       = state_r;
      accept_s       = 1'b0;
      take_int_s     = 1'b0;
      pipe.req_ready = 1'b0;
      csr_addr       = 14'd0;
      csr_re         = 1'b0;
      csr_we         = 1'b0;
      csr_wmask      = 32'd0;
      csr_wdata      = 32'd0;
      ex_en          = 1'b0;
      ecode          = 8'd0;
      esubcode       = 1'b0;
      pc             = 32'd0;
      vaddr          = 32'd0;
      case (state_r)
         ST_IDLE: begin
            pipe.req_ready = started_r & ~has_int;
            if (started_r && pipe.req_valid) begin
               take_int_s = has_int;
               accept_s   = ~has_int;
               state_nx   = ST_ACCESS;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (priv_fault_s) begin
               ex_en    = 1'b1;
               ecode    = ECODE_IPE;
               pc       = pc_r;
               state_nx = ST_FLUSH;
            end else begin
               case (op_r)
                  CSR_OP_RD: begin
                     csr_addr = num_r;
                     csr_re   = 1'b1;
                     state_nx = ST_RESP;
                  end
                  CSR_OP_WR, CSR_OP_XCHG: begin
                     csr_addr  = num_r;
                     csr_re    = 1'b1;
                     csr_we    = 1'b1;
                     csr_wmask = (op_r == CSR_OP_WR) ? 32'hFFFF_FFFF : mask_r;
                     csr_wdata = wdata_r;
                     state_nx  = ST_RESP;
                  end
                  CSR_OP_ERTN: begin
                     ecode    = ECODE_ERTN;
                     state_nx = ST_FLUSH;
                  end
                  CSR_OP_EXC: begin
                     ex_en    = 1'b1;
                     ecode    = ecode_r;
                     esubcode = esub_r;
                     pc       = pc_r;
                     vaddr    = vaddr_r;
                     state_nx = ST_FLUSH;
                  end
                  default: begin
                     // Undefined opcode: drop it without side effects.
                     state_nx = ST_IDLE;
                  end
               endcase
            end
         end
         ST_RESP: begin
            if (pipe.resp_ready) begin
               state_nx = (op_r == CSR_OP_RD) ? ST_IDLE : ST_FLUSH;
            end else begin
               state_nx = ST_RESP;
            end
         end
         ST_FLUSH: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Request latch, old-value capture and redirect PC selection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_r       <= CSR_OP_RD;
         num_r      <= 14'd0;
         wdata_r    <= 32'd0;
         mask_r     <= 32'd0;
         dest_r     <= '0;
         pc_r       <= 32'd0;
         ecode_r    <= 8'd0;
         esub_r     <= 1'b0;
         vaddr_r    <= 32'd0;
         rdata_r    <= 32'd0;
         flush_pc_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r    <= pipe.req_op;
                  num_r   <= pipe.req_csr_num;
                  wdata_r <= pipe.req_wdata;
                  mask_r  <= pipe.req_mask;
                  dest_r  <= pipe.req_dest;
                  pc_r    <= pipe.req_pc;
                  ecode_r <= pipe.req_ecode;
                  esub_r  <= pipe.req_esubcode;
                  vaddr_r <= pipe.req_vaddr;
               end else if (take_int_s) begin
                  op_r    <= CSR_OP_EXC;
                  pc_r    <= pipe.req_pc;
                  ecode_r <= int_ecode;
                  esub_r  <= 1'b0;
                  vaddr_r <= 32'd0;
               end
            end
            ST_ACCESS: begin
               if (priv_fault_s || (op_r == CSR_OP_EXC)) begin
                  flush_pc_r <= ex_entryPC;
               end else if (op_r == CSR_OP_ERTN) begin
                  flush_pc_r <= new_pc;
               end else begin
                  rdata_r <= csr_rdata;
               end
            end
            ST_RESP: begin
               if (pipe.resp_ready && (op_r != CSR_OP_RD)) begin
                  flush_pc_r <= next_pc(pc_r, PC_INC_W);
               end
            end
            default: begin
               flush_pc_r <= flush_pc_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit
//   Self-checking bench for csr_access_unit: directed scenarios plus a
//   randomized sequence scored against a behavioural model of the operations
//   and a small register-file model. Honours CSR_PRIV_CHECK_EN.
module tb_csr_access_unit;
   import csr_access_unit_pkg::*;

   localparam int DEST_W = 5;
   localparam int PC_INC = 4;

   logic        clk, rstn;
   logic [1:0]  csr_plv;
   logic [13:0] csr_addr;
   logic        csr_re, csr_we, ex_en, esubcode, has_int;
   logic [31:0] csr_wmask, csr_wdata, csr_rdata, pc, vaddr, new_pc, ex_entryPC;
   logic [7:0]  ecode, int_ecode;

   int checks = 0;
   int errors = 0;

   csr_access_unit_if #(.DEST_W(DEST_W)) bif ();

   csr_access_unit #(.DEST_W(DEST_W), .PC_INC(PC_INC)) dut (
      .clk(clk), .rstn(rstn), .pipe(bif), .csr_plv(csr_plv),
      .csr_addr(csr_addr), .csr_re(csr_re), .csr_we(csr_we),
      .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .ex_en(ex_en), .ecode(ecode), .esubcode(esubcode), .pc(pc), .vaddr(vaddr),
      .has_int(has_int), .int_ecode(int_ecode), .new_pc(new_pc), .ex_entryPC(ex_entryPC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return 32'h5A00_0000 | 32'(i);
   endfunction

   // Register file model: 16 entries aliased on csr_addr[3:0], masked writes.
   logic [31:0] file_regs [0:15];
   logic [31:0] shadow    [0:15];
   assign csr_rdata = file_regs[csr_addr[3:0]];
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 16; i++) file_regs[i] <= init_val(i);
      end else if (csr_we) begin
         file_regs[csr_addr[3:0]] <= (file_regs[csr_addr[3:0]] & ~csr_wmask) | (csr_wdata & csr_wmask);
      end
   end

   // Observation record filled by do_op.
   int                o_acc_cnt, o_acc_cyc, o_resp_cyc, o_resp_cnt, o_flush_cyc, o_flush_cnt;
   logic              o_rdy0, o_rdy_busy, o_rdy_after, o_resp_moved;
   logic [13:0]       o_addr;
   logic              o_re, o_we, o_ex_en, o_esub;
   logic [7:0]        o_ecode;
   logic [31:0]       o_wmask, o_wdata, o_pc, o_vaddr, o_rdata, o_flush_pc;
   logic [DEST_W-1:0] o_dest;

   task automatic apply_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
      @(negedge clk);
   endtask

   // Offers one operation, then watches 14 cycles and records what happened.
   task automatic do_op(input logic [2:0] op, input logic [13:0] num, input logic [31:0] wd,
                        input logic [31:0] mk, input logic [31:0] pcv, input logic [7:0] ec,
                        input logic es, input logic [31:0] va, input logic [DEST_W-1:0] dst,
                        input int delay);
      logic [15:0] rdy_hist;
      logic        file_any;
      int          last;
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_op = op; bif.req_csr_num = num; bif.req_wdata = wd;
      bif.req_mask = mk; bif.req_pc = pcv; bif.req_ecode = ec; bif.req_esubcode = es;
      bif.req_vaddr = va; bif.req_dest = dst; bif.resp_ready = 1'b0;
      #1 o_rdy0 = bif.req_ready;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      o_acc_cnt = 0; o_acc_cyc = 0; o_resp_cyc = 0; o_resp_cnt = 0; o_flush_cyc = 0;
      o_flush_cnt = 0; o_resp_moved = 1'b0; rdy_hist = 16'd0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         rdy_hist[k] = bif.req_ready;
         file_any = csr_re | csr_we | ex_en | esubcode | (ecode != 8'd0) | (csr_addr != 14'd0) |
                    (csr_wmask != 32'd0) | (csr_wdata != 32'd0) | (pc != 32'd0) | (vaddr != 32'd0);
         if (file_any) begin
            o_acc_cnt++;
            if (o_acc_cnt == 1) begin
               o_acc_cyc = k; o_addr = csr_addr; o_re = csr_re; o_we = csr_we; o_wmask = csr_wmask;
               o_wdata = csr_wdata; o_ex_en = ex_en; o_ecode = ecode; o_esub = esubcode;
               o_pc = pc; o_vaddr = vaddr;
            end
         end
         if (bif.resp_valid) begin
            o_resp_cnt++;
            if (o_resp_cnt == 1) begin
               o_resp_cyc = k; o_rdata = bif.resp_rdata; o_dest = bif.resp_dest;
            end else if (bif.resp_rdata !== o_rdata || bif.resp_dest !== o_dest) begin
               o_resp_moved = 1'b1;
            end
         end
         if (bif.flush_valid) begin
            o_flush_cnt++;
            if (o_flush_cnt == 1) begin
               o_flush_cyc = k; o_flush_pc = bif.flush_pc;
            end
         end
         bif.resp_ready = (o_resp_cyc > 0) && (k >= o_resp_cyc + delay);
      end
      bif.resp_ready = 1'b0;
      if (o_flush_cnt > 0) last = o_flush_cyc;
      else if (o_resp_cnt > 0) last = o_resp_cyc + o_resp_cnt - 1;
      else last = o_acc_cyc;
      o_rdy_busy = 1'b0;
      for (int j = 1; j <= last; j++) o_rdy_busy = o_rdy_busy | rdy_hist[j];
      o_rdy_after = rdy_hist[last + 1];
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bif.req_ready, bif.resp_valid, bif.resp_rdata, bif.resp_dest, bif.flush_valid, bif.flush_pc,
           csr_addr, csr_re, csr_we, csr_wmask, csr_wdata, ex_en, ecode, esubcode, pc, vaddr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req_ready=%b resp_valid=%b flush_valid=%b ecode=%h csr_re=%b, required all zero",
                  bif.req_ready, bif.resp_valid, bif.flush_valid, ecode, csr_re);
      end
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
      @(negedge clk);
      checks++;
      if (bif.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_rise: req_ready=%b, required 1", bif.req_ready);
      end
   endtask

   task automatic test_rd();
      do_op(CSR_OP_WR, 14'h005, 32'h0000_0800, 32'd0, 32'h1C00_0000, 8'd0, 1'b0, 32'd0, 5'd1, 0);
      do_op(CSR_OP_RD, 14'h005, 32'd0, 32'd0, 32'h1C00_0004, 8'd0, 1'b0, 32'd0, 5'd7, 0);
      checks++;
      if (o_acc_cnt !== 1 || o_acc_cyc !== 1 || o_re !== 1'b1 || o_we !== 1'b0 || o_addr !== 14'h005) begin
         errors++;
         $display("FAIL rd_access: cnt=%0d cyc=%0d re=%b we=%b addr=%h, required 1 1 1 0 005",
                  o_acc_cnt, o_acc_cyc, o_re, o_we, o_addr);
      end
      checks++;
      if (o_resp_cyc !== 2 || o_rdata !== 32'h0000_0800 || o_dest !== 5'd7 || o_flush_cnt !== 0) begin
         errors++;
         $display("FAIL rd_resp: cyc=%0d rdata=%h dest=%0d flushes=%0d, required 2 00000800 7 0",
                  o_resp_cyc, o_rdata, o_dest, o_flush_cnt);
      end
   endtask

   task automatic test_xchg();
      do_op(CSR_OP_WR, 14'h000, 32'h0000_0008, 32'd0, 32'h1C00_0008, 8'd0, 1'b0, 32'd0, 5'd0, 0);
      do_op(CSR_OP_XCHG, 14'h000, 32'h0000_0004, 32'h0000_0004, 32'h1C00_0010, 8'd0, 1'b0, 32'd0, 5'd3, 0);
      checks++;
      if (o_acc_cyc !== 1 || o_we !== 1'b1 || o_wmask !== 32'h0000_0004 || o_wdata !== 32'h0000_0004) begin
         errors++;
         $display("FAIL xchg_access: cyc=%0d we=%b wmask=%h wdata=%h, required 1 1 00000004 00000004",
                  o_acc_cyc, o_we, o_wmask, o_wdata);
      end
      checks++;
      if (o_resp_cyc !== 2 || o_rdata !== 32'h0000_0008 || o_flush_cyc !== 3 || o_flush_pc !== 32'h1C00_0014) begin
         errors++;
         $display("FAIL xchg_result: resp_cyc=%0d rdata=%h flush_cyc=%0d flush_pc=%h, required 2 00000008 3 1c000014",
                  o_resp_cyc, o_rdata, o_flush_cyc, o_flush_pc);
      end
      do_op(CSR_OP_RD, 14'h000, 32'd0, 32'd0, 32'h1C00_0018, 8'd0, 1'b0, 32'd0, 5'd3, 0);
      checks++;
      if (o_rdata !== 32'h0000_000C) begin
         errors++;
         $display("FAIL xchg_merge: rdata=%h, required 0000000c", o_rdata);
      end
   endtask

   task automatic test_ertn();
      new_pc = 32'h1C00_0100;
      do_op(CSR_OP_ERTN, 14'h000, 32'd0, 32'd0, 32'h1C00_0020, 8'd0, 1'b0, 32'd0, 5'd0, 0);
      checks++;
      if (o_acc_cnt !== 1 || o_ecode !== ECODE_ERTN || o_ex_en !== 1'b0 || o_re !== 1'b0) begin
         errors++;
         $display("FAIL ertn_access: cnt=%0d ecode=%h ex_en=%b re=%b, required 1 %h 0 0",
                  o_acc_cnt, o_ecode, o_ex_en, o_re, ECODE_ERTN);
      end
      checks++;
      if (o_flush_cyc !== 2 || o_flush_pc !== 32'h1C00_0100 || o_resp_cnt !== 0) begin
         errors++;
         $display("FAIL ertn_flush: cyc=%0d pc=%h resps=%0d, required 2 1c000100 0",
                  o_flush_cyc, o_flush_pc, o_resp_cnt);
      end
   endtask

   task automatic test_interrupt();
      has_int = 1'b1; int_ecode = 8'h4B; ex_entryPC = 32'h1C00_8000;
      do_op(CSR_OP_WR, 14'h003, 32'hDEAD_BEEF, 32'd0, 32'h1C00_0200, 8'h11, 1'b1, 32'h1234_0000, 5'd2, 0);
      checks++;
      if (o_rdy0 !== 1'b0 || o_ex_en !== 1'b1 || o_ecode !== 8'h4B || o_pc !== 32'h1C00_0200 ||
          o_vaddr !== 32'd0 || o_esub !== 1'b0 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL int_access: rdy=%b ex_en=%b ecode=%h pc=%h vaddr=%h esub=%b we=%b, required 0 1 4b 1c000200 0 0 0",
                  o_rdy0, o_ex_en, o_ecode, o_pc, o_vaddr, o_esub, o_we);
      end
      checks++;
      if (o_flush_cyc !== 2 || o_flush_pc !== 32'h1C00_8000 || o_resp_cnt !== 0) begin
         errors++;
         $display("FAIL int_flush: cyc=%0d pc=%h resps=%0d, required 2 1c008000 0", o_flush_cyc, o_flush_pc, o_resp_cnt);
      end
      has_int = 1'b0;
   endtask

   task automatic test_stall_and_reset();
      do_op(CSR_OP_RD, 14'h005, 32'd0, 32'd0, 32'h1C00_0300, 8'd0, 1'b0, 32'd0, 5'd9, 5);
      checks++;
      if (o_resp_cnt !== 6 || o_resp_moved !== 1'b0 || o_rdy_busy !== 1'b0 || o_rdy_after !== 1'b1) begin
         errors++;
         $display("FAIL stall_resp: cycles=%0d moved=%b ready_busy=%b ready_after=%b, required 6 0 0 1",
                  o_resp_cnt, o_resp_moved, o_rdy_busy, o_rdy_after);
      end
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_op = CSR_OP_RD; bif.req_csr_num = 14'h005; bif.resp_ready = 1'b0;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({bif.req_ready, bif.resp_valid, bif.resp_rdata, bif.resp_dest, bif.flush_valid, bif.flush_pc,
           csr_addr, csr_re, csr_we, csr_wmask, csr_wdata, ex_en, ecode, esubcode, pc, vaddr} !== '0) begin
         errors++;
         $display("FAIL midop_reset: resp_valid=%b resp_rdata=%h flush_pc=%h req_ready=%b, required all zero",
                  bif.resp_valid, bif.resp_rdata, bif.flush_pc, bif.req_ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
      @(negedge clk);
   endtask

   task automatic test_priv();
      csr_plv = 2'd3; ex_entryPC = 32'h1C00_9000;
      do_op(CSR_OP_WR, 14'h006, 32'h0000_FFFF, 32'd0, 32'h1C00_0400, 8'd0, 1'b0, 32'd0, 5'd4, 0);
`ifdef CSR_PRIV_CHECK_EN
      checks++;
      if (o_we !== 1'b0 || o_re !== 1'b0 || o_ecode !== 8'h0E || o_ex_en !== 1'b1 ||
          o_flush_pc !== 32'h1C00_9000 || o_flush_cyc !== 2 || o_resp_cnt !== 0) begin
         errors++;
         $display("FAIL priv_fault: we=%b re=%b ecode=%h ex_en=%b flush_pc=%h cyc=%0d resps=%0d, required 0 0 0e 1 1c009000 2 0",
                  o_we, o_re, o_ecode, o_ex_en, o_flush_pc, o_flush_cyc, o_resp_cnt);
      end
`else
      checks++;
      if (o_we !== 1'b1 || o_ex_en !== 1'b0 || o_resp_cnt !== 1 || o_flush_pc !== 32'h1C00_0404) begin
         errors++;
         $display("FAIL priv_ignored: we=%b ex_en=%b resps=%0d flush_pc=%h, required 1 0 1 1c000404",
                  o_we, o_ex_en, o_resp_cnt, o_flush_pc);
      end
`endif
      csr_plv = 2'd0;
   endtask

   // Random sequence against a behavioural model of each operation's effect.
   task automatic test_random_ops();
      logic [2:0]        op, eop;
      logic [13:0]       num;
      logic [31:0]       wd, mk, pcv, va, old, e_wmask, e_wdata, e_pc, e_vaddr, e_fpc;
      logic [7:0]        ec, e_ecode;
      logic              es, intp, fault, e_re, e_we, e_ex, e_es, e_resp, priv_on;
      logic [13:0]       e_addr;
      logic [DEST_W-1:0] dst;
      int                dly, e_fcyc;
`ifdef CSR_PRIV_CHECK_EN
      priv_on = 1'b1;
`else
      priv_on = 1'b0;
`endif
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 4)); num = 14'($urandom); wd = $urandom; mk = $urandom;
         pcv = $urandom; ec = 8'($urandom); es = 1'($urandom); va = $urandom; dst = DEST_W'($urandom);
         dly = $urandom_range(0, 3);
         intp = ($urandom_range(0, 7) == 0);
         has_int = intp; int_ecode = 8'($urandom); new_pc = $urandom; ex_entryPC = $urandom;
         csr_plv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         // Expected behaviour.
         eop = intp ? CSR_OP_EXC : op;
         if (intp) begin ec = int_ecode; es = 1'b0; va = 32'd0; end
         fault = priv_on && (csr_plv != 2'd0) && (eop != CSR_OP_EXC);
         old = shadow[num[3:0]];
         e_addr = 14'd0; e_re = 1'b0; e_we = 1'b0; e_wmask = 32'd0; e_wdata = 32'd0; e_ex = 1'b0;
         e_ecode = 8'd0; e_es = 1'b0; e_pc = 32'd0; e_vaddr = 32'd0; e_resp = 1'b0; e_fpc = 32'd0;
         if (fault) begin
            e_ex = 1'b1; e_ecode = ECODE_IPE; e_pc = pcv; e_fpc = ex_entryPC;
         end else if (eop == CSR_OP_RD) begin
            e_addr = num; e_re = 1'b1; e_resp = 1'b1;
         end else if (eop == CSR_OP_WR || eop == CSR_OP_XCHG) begin
            e_addr = num; e_re = 1'b1; e_we = 1'b1; e_wdata = wd; e_resp = 1'b1;
            e_wmask = (eop == CSR_OP_WR) ? 32'hFFFF_FFFF : mk;
            e_fpc = pcv + 32'(PC_INC);
            shadow[num[3:0]] = (old & ~e_wmask) | (wd & e_wmask);
         end else if (eop == CSR_OP_ERTN) begin
            e_ecode = ECODE_ERTN; e_fpc = new_pc;
         end else begin
            e_ex = 1'b1; e_ecode = ec; e_es = es; e_pc = pcv; e_vaddr = va; e_fpc = ex_entryPC;
         end
         e_fcyc = (e_resp && eop == CSR_OP_RD) ? 0 : (e_resp ? 3 + dly : 2);
         do_op(op, num, wd, mk, pcv, ec, es, va, dst, dly);
         checks++;
         if (o_acc_cnt !== 1 || o_acc_cyc !== 1 ||
             {o_addr, o_re, o_we, o_wmask, o_wdata, o_ex_en, o_ecode, o_esub, o_pc, o_vaddr} !==
             {e_addr, e_re, e_we, e_wmask, e_wdata, e_ex, e_ecode, e_es, e_pc, e_vaddr}) begin
            errors++;
            $display("FAIL rand_access[%0d] op=%0d int=%b: cnt=%0d cyc=%0d addr=%h re=%b we=%b wm=%h wd=%h ex=%b ec=%h es=%b pc=%h va=%h, required 1 1 %h %b %b %h %h %b %h %b %h %h",
                     n, op, intp, o_acc_cnt, o_acc_cyc, o_addr, o_re, o_we, o_wmask, o_wdata, o_ex_en, o_ecode,
                     o_esub, o_pc, o_vaddr, e_addr, e_re, e_we, e_wmask, e_wdata, e_ex, e_ecode, e_es, e_pc, e_vaddr);
         end
         checks++;
         if (o_rdy0 !== !intp || o_rdy_busy !== 1'b0 || o_rdy_after !== !intp) begin
            errors++;
            $display("FAIL rand_ready[%0d]: at_offer=%b busy=%b after=%b, required %b 0 %b",
                     n, o_rdy0, o_rdy_busy, o_rdy_after, !intp, !intp);
         end
         checks++;
         if (o_resp_cnt !== (e_resp ? 1 + dly : 0) ||
             (e_resp && (o_resp_cyc !== 2 || o_rdata !== old || o_dest !== dst || o_resp_moved !== 1'b0))) begin
            errors++;
            $display("FAIL rand_resp[%0d] op=%0d: cycles=%0d first=%0d rdata=%h dest=%0d moved=%b, required %0d 2 %h %0d 0",
                     n, op, o_resp_cnt, o_resp_cyc, o_rdata, o_dest, o_resp_moved, e_resp ? 1 + dly : 0, old, dst);
         end
         checks++;
         if (o_flush_cnt !== (e_fcyc != 0 ? 1 : 0) ||
             (e_fcyc != 0 && (o_flush_cyc !== e_fcyc || o_flush_pc !== e_fpc))) begin
            errors++;
            $display("FAIL rand_flush[%0d] op=%0d: count=%0d cyc=%0d pc=%h, required %0d %0d %h",
                     n, op, o_flush_cnt, o_flush_cyc, o_flush_pc, (e_fcyc != 0 ? 1 : 0), e_fcyc, e_fpc);
         end
      end
      has_int = 1'b0; csr_plv = 2'd0;
   endtask

   initial begin
      rstn = 1'b0; csr_plv = 2'd0; has_int = 1'b0; int_ecode = 8'd0;
      new_pc = 32'd0; ex_entryPC = 32'd0;
      bif.req_valid = 1'b0; bif.req_op = 3'd0; bif.req_csr_num = 14'd0; bif.req_wdata = 32'd0;
      bif.req_mask = 32'd0; bif.req_dest = '0; bif.req_pc = 32'd0; bif.req_ecode = 8'd0;
      bif.req_esubcode = 1'b0; bif.req_vaddr = 32'd0; bif.resp_ready = 1'b0;
      test_reset();
      test_rd();
      test_xchg();
      test_ertn();
      test_interrupt();
      test_stall_and_reset();
      test_priv();
      test_random_ops();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
